reg_write_arbiter: RTL and testbench

- Round-robin arbiter that shares one 32-bit enable-loaded register between N_REQ requesters.
- Typical requesters: game logic, score update, display refresh.
- Each cycle it picks at most one requester and drives the register's load enable and data. It supports locked multi-beat bursts capped at MAX_BURST beats.
- Sits directly in front of the shared register; its reg_ena and reg_data feed that register's ena and data_in.

---
 rtl/reg_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 34 +++
 rtl/reg_write_arbiter.sv | 108 ++++++++++
 tb/tb_reg_write_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared types and helpers for the register write arbiter
package reg_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int DW_DEFAULT = 32;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first candidate at or after ptr
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int OW    = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] cand,
    input  logic [OW-1:0]    ptr,
    output logic             found,
    output logic [OW-1:0]    win
);

    logic [N_REQ-1:0] rot;
    logic [OW-1:0]    off;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate the index back.
    always_comb begin
        rot   = '0;
        found = 1'b0;
        off   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = cand[(i + int'(ptr)) % N_REQ];
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = OW'(i);
            end
        end
        win = OW'((int'(off) + int'(ptr)) % N_REQ);
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter with locked bursts in front of a shared register
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int DW        = DW_DEFAULT,
    parameter  int MAX_BURST = 8,
    localparam int OW        = clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    lock,
    input  logic [N_REQ*DW-1:0] data_in,
    output logic [N_REQ-1:0]    gnt,
    output logic                reg_ena,
    output logic [DW-1:0]       reg_data,
    output logic [OW-1:0]       owner,
    output logic                busy
);

    arb_state_t       state, state_n;
    logic [OW-1:0]    ptr, ptr_n, owner_n, win;
    logic [7:0]       bcnt, bcnt_n, bcnt_inc;
    logic [N_REQ-1:0] gnt_n, cand;
    logic [DW-1:0]    data_n;
    logic             ena_n, found;

    // A requester granted last cycle sits out one IDLE decision so a single write is not taken twice.
    assign cand     = req & ~gnt;
    assign bcnt_inc = bcnt + 8'd1;
    assign busy     = (state == LOCKED);

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .cand  (cand),
        .ptr   (ptr),
        .found (found),
        .win   (win)
    );

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        bcnt_n  = bcnt;
        gnt_n   = '0;
        ena_n   = 1'b0;
        data_n  = reg_data;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_n[win] = 1'b1;
                    ena_n      = 1'b1;
                    data_n     = data_in[int'(win)*DW +: DW];
                    owner_n    = win;
                    ptr_n      = (win == OW'(N_REQ - 1)) ? '0 : win + OW'(1);
                    if (lock[win] && (MAX_BURST > 1)) begin
                        state_n = LOCKED;
                        bcnt_n  = 8'd1;
                    end
                end
            end
            LOCKED: begin
                if (req[owner]) begin
                    gnt_n[owner] = 1'b1;
                    ena_n        = 1'b1;
                    data_n       = data_in[int'(owner)*DW +: DW];
                    if (lock[owner] && (int'(bcnt_inc) < MAX_BURST)) begin
                        bcnt_n = bcnt_inc;
                    end else begin
                        state_n = IDLE;
                        bcnt_n  = 8'd0;
                    end
                end else begin
                    state_n = IDLE;
                    bcnt_n  = 8'd0;
                end
            end
            default: begin
                state_n = IDLE;
                bcnt_n  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            bcnt     <= 8'd0;
            gnt      <= '0;
            reg_ena  <= 1'b0;
            reg_data <= '0;
            owner    <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            bcnt     <= bcnt_n;
            gnt      <= gnt_n;
            reg_ena  <= ena_n;
            reg_data <= data_n;
            owner    <= owner_n;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - scoreboard bench for reg_write_arbiter against a behavioural model
module tb_reg_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 8;
    localparam int OW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    lock;
    logic [N*DW-1:0] data_in;
    logic [N-1:0]    gnt;
    logic            reg_ena;
    logic [DW-1:0]   reg_data;
    logic [OW-1:0]   owner;
    logic            busy;

    always #5 clk = ~clk;

    reg_write_arbiter #(
        .N_REQ     (N),
        .DW        (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .lock     (lock),
        .data_in  (data_in),
        .gnt      (gnt),
        .reg_ena  (reg_ena),
        .reg_data (reg_data),
        .owner    (owner),
        .busy     (busy)
    );

    typedef struct {
        logic [N-1:0]  gnt;
        logic [DW-1:0] data;
        int            owner;
        logic          busy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the register port should show after each rising edge.
    bit            m_locked = 1'b0;
    int            m_ptr    = 0;
    int            m_owner  = 0;
    int            m_beats  = 0;
    logic [N-1:0]  m_gnt    = '0;
    logic [DW-1:0] m_data   = '0;

    always @(posedge clk) begin : model
        int   w;
        exp_t e;
        if (rst) begin
            m_locked = 1'b0;
            m_ptr    = 0;
            m_owner  = 0;
            m_beats  = 0;
            m_gnt    = '0;
            m_data   = '0;
        end else if (!m_locked) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(m_ptr + k) % N] && !m_gnt[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            if (w >= 0) begin
                m_gnt   = N'(1) << w;
                m_data  = data_in[w*DW +: DW];
                m_owner = w;
                m_ptr   = (w + 1) % N;
                if (lock[w] && MB > 1) begin
                    m_locked = 1'b1;
                    m_beats  = 1;
                end
            end else begin
                m_gnt = '0;
            end
        end else if (req[m_owner]) begin
            m_gnt   = N'(1) << m_owner;
            m_data  = data_in[m_owner*DW +: DW];
            m_beats = m_beats + 1;
            if (!(lock[m_owner] && m_beats < MB)) begin
                m_locked = 1'b0;
                m_beats  = 0;
            end
        end else begin
            m_gnt    = '0;
            m_locked = 1'b0;
            m_beats  = 0;
        end
        e.gnt   = m_gnt;
        e.data  = m_data;
        e.owner = m_owner;
        e.busy  = m_locked;
        sb.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_gnt", 64'(gnt), 64'(e.gnt));
            chk("sb_reg_ena", 64'(reg_ena), 64'(|e.gnt));
            chk("sb_reg_data", 64'(reg_data), 64'(e.data));
            chk("sb_owner", 64'(owner), 64'(e.owner));
            chk("sb_busy", 64'(busy), 64'(e.busy));
        end
    end

    task automatic pulse_reset();
        @(negedge clk);
        rst  = 1'b1;
        req  = '0;
        lock = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b1111;
        lock = '0;
        for (int i = 0; i < N; i++) data_in[i*DW +: DW] = 32'h100 + i;

        // reset held with all requesters asking
        repeat (2) begin
            @(negedge clk);
            chk("rst_gnt", 64'(gnt), 64'h0);
            chk("rst_ena", 64'(reg_ena), 64'h0);
            chk("rst_data", 64'(reg_data), 64'h0);
            chk("rst_owner", 64'(owner), 64'h0);
            chk("rst_busy", 64'(busy), 64'h0);
        end
        rst = 1'b0;

        // round robin with everyone requesting
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_gnt", 64'(gnt), 64'(4'b0001 << (k % 4)));
            chk("rr_data", 64'(reg_data), 64'(32'h100 + (k % 4)));
        end
        req = '0;
        repeat (2) @(negedge clk);

        // single write from requester 2
        data_in[2*DW +: DW] = 32'hAA;
        req = 4'b0100;
        @(negedge clk);
        chk("single_gnt", 64'(gnt), 64'h4);
        chk("single_ena", 64'(reg_ena), 64'h1);
        chk("single_data", 64'(reg_data), 64'hAA);
        chk("single_owner", 64'(owner), 64'h2);
        req = '0;
        @(negedge clk);
        chk("single_ena_off", 64'(reg_ena), 64'h0);
        chk("single_data_hold", 64'(reg_data), 64'hAA);

        // lone requester is self-masked on alternate cycles
        req = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("selfmask_gnt", 64'(gnt), (k % 2 == 0) ? 64'h2 : 64'h0);
        end

        // full locked burst, requester 0 waiting
        pulse_reset();
        req  = 4'b1000;
        lock = 4'b1000;
        @(negedge clk);
        chk("burst_b1", 64'(gnt), 64'h8);
        chk("burst_busy", 64'(busy), 64'h1);
        req = 4'b1001;
        repeat (7) begin
            @(negedge clk);
            chk("burst_beat", 64'(gnt), 64'h8);
        end
        @(negedge clk);
        chk("burst_after", 64'(gnt), 64'h1);
        req  = '0;
        lock = '0;

        // burst with lock dropped after beat 3
        pulse_reset();
        req  = 4'b1000;
        lock = 4'b1000;
        @(negedge clk);
        req = 4'b1001;
        @(negedge clk);
        @(negedge clk);
        chk("early_b3", 64'(gnt), 64'h8);
        lock = '0;
        @(negedge clk);
        chk("early_b4", 64'(gnt), 64'h8);
        chk("early_b4_busy", 64'(busy), 64'h0);
        @(negedge clk);
        chk("early_after", 64'(gnt), 64'h1);
        req = '0;

        // reset during beat 4
        pulse_reset();
        req  = 4'b1000;
        lock = 4'b1000;
        repeat (4) @(negedge clk);
        chk("midrst_b4", 64'(gnt), 64'h8);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_gnt", 64'(gnt), 64'h0);
        chk("midrst_busy", 64'(busy), 64'h0);
        rst  = 1'b0;
        req  = 4'b0010;
        lock = '0;
        @(negedge clk);
        chk("midrst_next", 64'(gnt), 64'h2);
        chk("midrst_owner", 64'(owner), 64'h1);

        // randomized traffic, occasional reset
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 199) == 0);
            req  = N'($urandom);
            lock = N'($urandom);
            for (int i = 0; i < N; i++) data_in[i*DW +: DW] = $urandom;
        end
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
